// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, frame width, PISO state encoding
// and the frame-length helper used by the TX serializer.
package uart_pkg;

    localparam int FRAME_W = 12;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_SHIFT = ST_SHIFT_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    // Number of bits on the line: start + 7 data + optional 8th data bit
    // + optional parity + one or two stops, i.e. 9..12.
    function automatic logic [3:0] frame_len(input logic       data_length,
                                             input logic [1:0] parity_type,
                                             input logic       stop_bits);
        logic parEn;
        case (parity_type)
            PAR_ODD, PAR_EVEN:   parEn = 1'b1;
            PAR_NONE, PAR_NONE2: parEn = 1'b0;
            default:             parEn = 1'b0;
        endcase
        return 4'd9 + {3'b000, data_length} + {3'b000, parEn} + {3'b000, stop_bits};
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the last
// clock of each bit period. Shared with the RX sampler.
module uart_baud_cnt #(
    parameter int BAUD_DIV = 5208
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_bit_tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] r_count;

    // Free-running bit-period count, held at zero while cleared
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (r_count == CNT_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_bit_tick = i_enable && (r_count == CNT_LAST);

endmodule

// File: rtl/uart_piso.sv
// UART TX serializer: latches an LSB-first frame on send and shifts the
// configured number of bits onto the line, BAUD_DIV clocks per bit.
// Optional line-break support is enabled with macro UART_PISO_BREAK_EN.
module uart_piso
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 5208
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_send,
    input  logic [FRAME_W-1:0] i_frame_in,
    input  logic               i_data_length,
    input  logic [1:0]         i_parity_type,
    input  logic               i_stop_bits,
`ifdef UART_PISO_BREAK_EN
    input  logic               i_break_req,
`endif
    output logic               o_tx_out,
    output logic               o_busy,
    output logic               o_done
);

    state_t             r_state;
    state_t             w_next_state;
    logic [FRAME_W-1:0] r_sreg;
    logic [FRAME_W-1:0] w_sreg_next;
    logic [3:0]         r_bitcnt;
    logic [3:0]         r_len;
    logic               r_tx;
    logic               r_busy;
    logic               r_done;
    logic               w_tx_next;
    logic               w_busy_next;
    logic               w_done_next;
    logic               w_bit_tick;
    logic               w_break;
    logic               w_accept;
    logic               w_last_bit;

`ifdef UART_PISO_BREAK_EN
    assign w_break = i_break_req && (r_state == ST_IDLE);
`else
    assign w_break = 1'b0;
`endif

    assign w_accept   = (r_state == ST_IDLE) && i_send && !w_break;
    assign w_last_bit = w_bit_tick && (r_bitcnt == (r_len - 4'd1));

    uart_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (r_state != ST_SHIFT),
        .i_enable   (r_state == ST_SHIFT),
        .o_bit_tick (w_bit_tick)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: start on accepted send, finish after the last bit period
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)   w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_next_state = ST_DONE;
            ST_DONE:                  w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    // Shift register next value: load on accept, shift in 1s at each bit boundary
    always_comb begin
        w_sreg_next = r_sreg;
        if (w_accept) begin
            w_sreg_next = i_frame_in;
        end else if ((r_state == ST_SHIFT) && w_bit_tick) begin
            w_sreg_next = {1'b1, r_sreg[FRAME_W-1:1]};
        end
    end

    // Frame datapath: shift register, latched length and bit counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sreg   <= '1;
            r_len    <= '0;
            r_bitcnt <= '0;
        end else begin
            r_sreg <= w_sreg_next;
            if (w_accept) begin
                r_len    <= frame_len(i_data_length, i_parity_type, i_stop_bits);
                r_bitcnt <= '0;
            end else if ((r_state == ST_SHIFT) && w_bit_tick) begin
                r_bitcnt <= r_bitcnt + 4'd1;
            end
        end
    end

    // Output decode from the upcoming state so the outputs can be registered
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_next_state)
            ST_SHIFT: begin
                w_tx_next   = w_sreg_next[0];
                w_busy_next = 1'b1;
            end
            ST_DONE: begin
                w_done_next = 1'b1;
            end
            default: begin
                w_tx_next   = !w_break;
                w_busy_next = w_break;
            end
        endcase
    end

    // Registered outputs so nothing combinational reaches the line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

    assign o_tx_out = r_tx;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule
